// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and command-field layout for the A2D round-robin scheduler
package a2d_pkg;
  typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, READ, WAIT2} state_t;
  typedef enum logic [1:0] {LFT, RGHT, BATT} ch_sel_t;
  localparam int CMD_CH_LSB = 11;
  localparam int CMD_CH_W = 3;
  function automatic ch_sel_t ch_next(input ch_sel_t c);
    return c == LFT ? RGHT : c == RGHT ? BATT : LFT;
  endfunction
  function automatic logic [15:0] cmd_word(input logic [CMD_CH_W-1:0] c);
    logic [15:0] w;
    w = '0;
    w[CMD_CH_LSB +: CMD_CH_W] = c;
    return w;
  endfunction
endpackage

// File: rtl/a2d_rr_sched.sv
// a2d_rr_sched: round-robin A2D sampler issuing two SPI frames per conversion
module a2d_rr_sched
  import a2d_pkg::*;
#(
  parameter logic [2:0] LFT_CH = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        busy
);
  state_t state, state_nxt;
  ch_sel_t ptr;
  logic [2:0] ch_num;
  logic cap;
  logic unused_hi;
  assign unused_hi = ^rd_data[15:12];
  assign ch_num = ptr == LFT ? LFT_CH : ptr == RGHT ? RGHT_CH : BATT_CH;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = nxt ? CMD : IDLE;
      CMD:     state_nxt = WAIT1;
      WAIT1:   state_nxt = done ? GAP : WAIT1;
      GAP:     state_nxt = READ;
      READ:    state_nxt = WAIT2;
      WAIT2:   state_nxt = done ? IDLE : WAIT2;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    wrt = state == CMD || state == READ;
    busy = state != IDLE;
    cap = state == WAIT2 && done;
  end
  // cmd is latched when the conversion is accepted so both frames carry the same word
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr <= LFT;
      cmd <= '0;
      lft_ld <= '0;
      rght_ld <= '0;
      batt <= '0;
    end else begin
      if (state == IDLE && nxt) cmd <= cmd_word(ch_num);
      if (cap) ptr <= ch_next(ptr);
      lft_ld <= cap && ptr == LFT ? rd_data[11:0] : lft_ld;
      rght_ld <= cap && ptr == RGHT ? rd_data[11:0] : rght_ld;
      batt <= cap && ptr == BATT ? rd_data[11:0] : batt;
    end
endmodule

// File: tb/tb_a2d_rr_sched.sv
// tb_a2d_rr_sched: directed checks of the A2D round-robin scheduler against hand-computed values
module tb_a2d_rr_sched;
  logic clk = 0;
  logic rst_n = 0;
  logic nxt = 0;
  logic done = 0;
  logic [15:0] rd_data = '0;
  logic wrt, busy;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;
  int vectors = 0;
  int miscompares = 0;
  int wrt_cnt = 0;
  a2d_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (wrt) wrt_cnt <= wrt_cnt + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_regs(input string tag, input logic [11:0] l, input logic [11:0] r, input logic [11:0] b);
    check({tag, "_lft"}, 32'(lft_ld), 32'(l));
    check({tag, "_rght"}, 32'(rght_ld), 32'(r));
    check({tag, "_batt"}, 32'(batt), 32'(b));
  endtask
  // spur: nxt in WAIT1/WAIT2 and done in GAP; coinc: nxt together with the final done
  task automatic conv(input string tag, input logic [15:0] ret, input logic [15:0] ecmd, input bit spur, input bit coinc);
    int w0;
    w0 = wrt_cnt;
    check({tag, "_idle_busy"}, 32'(busy), 0);
    nxt = 1;
    tick;
    nxt = 0;
    check({tag, "_cmd_wrt"}, 32'(wrt), 1);
    check({tag, "_cmd_word"}, 32'(cmd), 32'(ecmd));
    check({tag, "_busy"}, 32'(busy), 1);
    tick;
    check({tag, "_wait1_wrt"}, 32'(wrt), 0);
    nxt = spur;
    tick;
    nxt = 0;
    tick;
    done = 1;
    rd_data = 16'hBEEF;
    tick;
    done = spur;
    rd_data = 16'h0BAD;
    check({tag, "_gap_wrt"}, 32'(wrt), 0);
    tick;
    done = 0;
    check({tag, "_read_wrt"}, 32'(wrt), 1);
    check({tag, "_read_cmd"}, 32'(cmd), 32'(ecmd));
    tick;
    nxt = spur;
    tick;
    nxt = 0;
    tick;
    check({tag, "_wait2_busy"}, 32'(busy), 1);
    done = 1;
    rd_data = ret;
    nxt = coinc;
    tick;
    done = 0;
    nxt = 0;
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_wrt_pulses"}, 32'(wrt_cnt - w0), 2);
  endtask
  initial begin
    tick;
    tick;
    check("rst_wrt", 32'(wrt), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_busy", 32'(busy), 0);
    check_regs("rst", 12'h000, 12'h000, 12'h000);
    rst_n = 1;
    tick;
    conv("first", 16'hFA53, 16'h0000, 1, 0);
    check_regs("first", 12'hA53, 12'h000, 12'h000);
    rst_n = 0;
    tick;
    rst_n = 1;
    check_regs("rst2", 12'h000, 12'h000, 12'h000);
    conv("lft", 16'hF111, 16'h0000, 0, 0);
    check_regs("lft", 12'h111, 12'h000, 12'h000);
    conv("rght", 16'h8222, 16'h2000, 0, 0);
    check_regs("rght", 12'h111, 12'h222, 12'h000);
    conv("batt", 16'h4333, 16'h2800, 0, 0);
    check_regs("batt", 12'h111, 12'h222, 12'h333);
    conv("wrap", 16'h0444, 16'h0000, 0, 0);
    check_regs("wrap", 12'h444, 12'h222, 12'h333);
    check("wrap_cmd_hold", 32'(cmd), 32'h0000);
    nxt = 1;
    tick;
    nxt = 0;
    tick;
    done = 1;
    tick;
    done = 0;
    tick;
    tick;
    check("abort_in_wait2", 32'(busy), 1);
    rst_n = 0;
    tick;
    rst_n = 1;
    done = 1;
    rd_data = 16'hFFFF;
    tick;
    done = 0;
    check("abort_busy", 32'(busy), 0);
    check("abort_wrt", 32'(wrt), 0);
    check("abort_cmd", 32'(cmd), 0);
    check_regs("abort", 12'h000, 12'h000, 12'h000);
    done = 1;
    rd_data = 16'h0777;
    tick;
    done = 0;
    check("idle_done_busy", 32'(busy), 0);
    check("idle_done_wrt", 32'(wrt), 0);
    check_regs("idle_done", 12'h000, 12'h000, 12'h000);
    conv("coinc", 16'h1ABC, 16'h0000, 1, 1);
    check_regs("coinc", 12'hABC, 12'h000, 12'h000);
    for (int i = 0; i < 3; i++) begin
      check("coinc_no_wrt", 32'(wrt), 0);
      check("coinc_idle", 32'(busy), 0);
      tick;
    end
    conv("after", 16'h0555, 16'h2000, 0, 0);
    check_regs("after", 12'hABC, 12'h555, 12'h000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/a2d_rr_sched.md
A2D_RR_SCHED -- requirements
Module: a2d_rr_sched

Interface
REQ-001 SHALL have parameter LFT_CH, default 3'd0, A2D channel of left load cell.
REQ-002 SHALL have parameter RGHT_CH, default 3'd4, A2D channel of right load cell.
REQ-003 SHALL have parameter BATT_CH, default 3'd5, A2D channel of battery divider.
REQ-004 clk  input  1  system clock; single clock domain, all logic on posedge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 nxt  input  1  one-cycle request to start one conversion on the current round-robin channel.
REQ-007 wrt  output  1  one-cycle strobe to the external SPI master to start a 16-bit transaction.
REQ-008 cmd  output  16  SPI command word, valid when wrt is high.
REQ-009 done  input  1  one-cycle SPI master completion strobe.
REQ-010 rd_data  input  16  SPI master received word, valid when done is high.
REQ-011 lft_ld  output  12  last left-load result.
REQ-012 rght_ld  output  12  last right-load result.
REQ-013 batt  output  12  last battery result.
REQ-014 busy  output  1  high from cycle after an accepted nxt until the result register updates.

Function
REQ-015 States SHALL be IDLE, CMD, WAIT1, GAP, READ, WAIT2.
REQ-016 IDLE: nxt high -> CMD next cycle; otherwise stay in IDLE.
REQ-017 CMD: wrt=1 for exactly one cycle, cmd={2'b00, ch[2:0], 11'h000} -> WAIT1.
REQ-018 WAIT1: wait for done; done -> GAP; rd_data ignored in this state.
REQ-019 GAP: one idle cycle, required by the A2D between frames -> READ.
REQ-020 READ: wrt=1 for one cycle with the same cmd as CMD -> WAIT2.
REQ-021 WAIT2: on done, rd_data[11:0] SHALL be captured into the register for the current channel; the register output SHALL be visible the next cycle; -> IDLE.
REQ-022 The round-robin pointer SHALL advance LFT -> RGHT -> BATT -> LFT on the WAIT2 done cycle; it wraps after BATT.
REQ-023 nxt asserted in any state other than IDLE SHALL be ignored, not queued.
REQ-024 nxt and done high in the same WAIT2 cycle: the capture completes and nxt is ignored; the next conversion needs a fresh nxt in IDLE.
REQ-025 done seen in IDLE, CMD, GAP or READ SHALL be ignored.
REQ-026 cmd SHALL hold its last value when wrt is low; it is 16'h0000 after reset.
REQ-027 rd_data[15:12] SHALL be discarded; no sign extension.
REQ-028 Minimum latency from nxt to result update SHALL be 5 cycles plus the two SPI transaction durations.

Reset
REQ-029 rst_n low on a clock edge SHALL force state IDLE, pointer LFT, wrt=0, cmd=0, busy=0, lft_ld=rght_ld=batt=12'h000.
REQ-030 Reset asserted mid-conversion SHALL abandon the conversion with no register update; a done arriving after reset release SHALL be ignored (REQ-025).

Structure
REQ-031 Shared package a2d_pkg SHALL hold the state enum, the channel-select enum (LFT, RGHT, BATT), and the cmd field positions.
REQ-032 No sub-module SHALL be instantiated; the SPI master stays external and connects via wrt/cmd/done/rd_data.

Verification
REQ-033 Reset, then nxt pulse with SPI model returning 16'hFA53 on the second frame -> two wrt pulses, each with cmd=16'h0000; lft_ld=12'hA53 one cycle after the second done; rght_ld and batt stay 0.
REQ-034 Three nxt pulses, each issued after busy falls, with the model returning 12'h111/12'h222/12'h333 -> cmd 16'h0000, 16'h2000, 16'h2800 in order; lft_ld=111, rght_ld=222, batt=333; a fourth nxt reuses cmd 16'h0000 (wrap).
REQ-035 nxt pulsed during WAIT1 and again during WAIT2 -> no extra wrt; exactly 2 wrt pulses per conversion.
REQ-036 rst_n low during WAIT2, then done -> all outputs 0, no capture, pointer back at LFT.
REQ-037 Spurious done in IDLE and in GAP -> no state change, no register update; GAP still lasts exactly 1 cycle (wrt two cycles after the first done).
REQ-038 nxt and done coincident in WAIT2 -> capture occurs, busy falls, no wrt in the following 3 cycles.
